// File: rtl/sample_capture_if.sv
// Bundles the sample stream, capture control, read port and status of sample_capture.
interface sample_capture_if #(
  parameter int SAMPLER_DATA_SIZE = 16,
  parameter int ADDR_WIDTH        = 10,
  parameter int DECIMATION_WIDTH  = 8
);
  logic [SAMPLER_DATA_SIZE-1:0] i_reference;
  logic [SAMPLER_DATA_SIZE-1:0] i_error;
  logic                         i_valid;
  logic                         i_start;
  logic                         i_stop;
  logic [DECIMATION_WIDTH-1:0]  i_decimation;
  logic                         i_rd_en;
  logic [ADDR_WIDTH-1:0]        i_rd_addr;
  logic [SAMPLER_DATA_SIZE-1:0] o_rd_reference;
  logic [SAMPLER_DATA_SIZE-1:0] o_rd_error;
  logic                         o_rd_valid;
  logic                         o_busy;
  logic                         o_done;
  logic [ADDR_WIDTH:0]          o_count;

  modport slave (
    input  i_reference, i_error, i_valid, i_start, i_stop, i_decimation, i_rd_en, i_rd_addr,
    output o_rd_reference, o_rd_error, o_rd_valid, o_busy, o_done, o_count
  );

  modport master (
    output i_reference, i_error, i_valid, i_start, i_stop, i_decimation, i_rd_en, i_rd_addr,
    input  o_rd_reference, o_rd_error, o_rd_valid, o_busy, o_done, o_count
  );
endinterface

// File: rtl/sample_capture.sv
// Decimating capture of reference/error sample pairs into a dual-port buffer,
// with a registered read-first random-access read port.
module sample_capture #(
  parameter int SAMPLER_DATA_SIZE = 16,
  parameter int ADDR_WIDTH        = 10,
  parameter int DECIMATION_WIDTH  = 8
) (
  input logic             i_clock,
  input logic             i_reset,
  sample_capture_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = 2*SAMPLER_DATA_SIZE;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t                      state, state_nxt;
  logic [ADDR_WIDTH-1:0]       wr_ptr;
  logic [ADDR_WIDTH:0]         count;
  logic [DECIMATION_WIDTH-1:0] dec_cnt, dec_limit;
  logic                        launch, wr_en, full;
  logic [PW-1:0]               mem [DEPTH];
  logic [PW-1:0]               rd_q;
  logic                        rd_vld_q;

  assign launch = (state != CAPTURE) && bus.i_start;
  assign wr_en  = (state == CAPTURE) && bus.i_valid && (dec_cnt == '0);
  // Pointer never wraps: the write into the last slot ends the run.
  assign full   = wr_en && (&wr_ptr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.i_start) state_nxt = CAPTURE;
      CAPTURE:    if (bus.i_stop || full) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      dec_cnt   <= '0;
      dec_limit <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        dec_limit <= bus.i_decimation;
        wr_ptr    <= '0;
        count     <= '0;
        dec_cnt   <= '0;
      end else if (state == CAPTURE && bus.i_valid) begin
        dec_cnt <= (dec_cnt == dec_limit) ? '0 : dec_cnt + 1'b1;
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
      end
    end
  end

  // Buffer has no reset so it maps onto block RAM and survives reset.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_ptr] <= {bus.i_reference, bus.i_error};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= bus.i_rd_en;
      if (bus.i_rd_en) rd_q <= mem[bus.i_rd_addr];
    end
  end

  assign bus.o_rd_reference = rd_q[PW-1 -: SAMPLER_DATA_SIZE];
  assign bus.o_rd_error     = rd_q[SAMPLER_DATA_SIZE-1:0];
  assign bus.o_rd_valid     = rd_vld_q;
  assign bus.o_busy         = (state == CAPTURE);
  assign bus.o_done         = (state == DONE);
  assign bus.o_count        = count;
endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with an 8-entry buffer.
module tb_sample_capture;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_capture_if #(.SAMPLER_DATA_SIZE(DW), .ADDR_WIDTH(AW), .DECIMATION_WIDTH(CW)) bus();

  sample_capture #(.SAMPLER_DATA_SIZE(DW), .ADDR_WIDTH(AW), .DECIMATION_WIDTH(CW)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_reference  = '0;
    bus.i_error      = '0;
    bus.i_valid      = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_decimation = '0;
    bus.i_rd_en      = 1'b0;
    bus.i_rd_addr    = '0;
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] e);
    bus.i_reference = r;
    bus.i_error     = e;
    bus.i_valid     = 1'b1;
    tick();
    bus.i_valid     = 1'b0;
  endtask

  task automatic start(input logic [CW-1:0] d);
    bus.i_decimation = d;
    bus.i_start      = 1'b1;
    tick();
    bus.i_start      = 1'b0;
  endtask

  task automatic stop();
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] r, output logic [DW-1:0] e,
                    output logic v);
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = a;
    tick();
    r = bus.o_rd_reference;
    e = bus.o_rd_error;
    v = bus.o_rd_valid;
    bus.i_rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.o_done); end
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.o_count); end
    checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", bus.o_rd_valid); end
    checks++; if (bus.o_rd_reference !== 16'h0) begin errors++; $display("FAIL rst_rd_ref got %h exp 0000", bus.o_rd_reference); end
    checks++; if (bus.o_rd_error !== 16'h0) begin errors++; $display("FAIL rst_rd_err got %h exp 0000", bus.o_rd_error); end
  endtask

  task automatic test_full_run();
    logic [DW-1:0] r, e, xe;
    logic v;
    start(8'd0);
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL full_busy_start got %b exp 1", bus.o_busy); end
    for (int k = 0; k < 8; k++) begin
      send(16'h0100 + 16'(k), 16'h2000 - 16'(k));
      if (k < 7) begin
        checks++; if (bus.o_busy !== 1'b1 || bus.o_count !== 4'(k + 1))
          begin errors++; $display("FAIL full_progress[%0d] busy %b count %0d exp busy 1 count %0d", k, bus.o_busy, bus.o_count, k + 1); end
      end
    end
    checks++; if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0)
      begin errors++; $display("FAIL full_done done %b busy %b exp done 1 busy 0", bus.o_done, bus.o_busy); end
    checks++; if (bus.o_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", bus.o_count); end
    for (int k = 0; k < 8; k++) begin
      rd(3'(k), r, e, v);
      xe = 16'h2000 - 16'(k);
      checks++; if (r !== 16'h0100 + 16'(k) || e !== xe || v !== 1'b1)
        begin errors++; $display("FAIL full_rd[%0d] got %h/%h v%b exp %h/%h v1", k, r, e, v, 16'h0100 + 16'(k), xe); end
    end
    tick();
    checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_rd_reference !== 16'h0107)
      begin errors++; $display("FAIL rd_hold valid %b ref %h exp valid 0 ref 0107", bus.o_rd_valid, bus.o_rd_reference); end
  endtask

  task automatic test_start_stop_together();
    start(8'd0);
    for (int k = 0; k < 8; k++) send(16'h0600 + 16'(k), 16'(k));
    checks++; if (bus.o_done !== 1'b1 || bus.o_count !== 4'd8)
      begin errors++; $display("FAIL ss_pre done %b count %0d exp done 1 count 8", bus.o_done, bus.o_count); end
    bus.i_stop = 1'b1;
    start(8'd0);
    bus.i_stop = 1'b0;
    checks++; if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0 || bus.o_count !== 4'd0)
      begin errors++; $display("FAIL ss_start busy %b done %b count %0d exp 1 0 0", bus.o_busy, bus.o_done, bus.o_count); end
    stop();
    checks++; if (bus.o_done !== 1'b1 || bus.o_count !== 4'd0)
      begin errors++; $display("FAIL ss_empty_stop done %b count %0d exp done 1 count 0", bus.o_done, bus.o_count); end
  endtask

  task automatic test_decimation();
    logic [DW-1:0] r, e, xr;
    logic v;
    start(8'd2);
    for (int k = 0; k < 10; k++) begin
      send(16'(k), 16'hF000 | 16'(k));
      tick();
    end
    stop();
    checks++; if (bus.o_done !== 1'b1 || bus.o_count !== 4'd4)
      begin errors++; $display("FAIL dec_count done %b count %0d exp done 1 count 4", bus.o_done, bus.o_count); end
    for (int i = 0; i < 4; i++) begin
      rd(3'(i), r, e, v);
      xr = 16'(3 * i);
      checks++; if (r !== xr || e !== (16'hF000 | xr))
        begin errors++; $display("FAIL dec_rd[%0d] got %h/%h exp %h/%h", i, r, e, xr, 16'hF000 | xr); end
    end
  endtask

  task automatic test_stop_with_write();
    logic [DW-1:0] r, e;
    logic v;
    start(8'd0);
    for (int k = 0; k < 3; k++) send(16'h0300 + 16'(k), 16'h0030 + 16'(k));
    start(8'd5);
    checks++; if (bus.o_busy !== 1'b1 || bus.o_count !== 4'd3)
      begin errors++; $display("FAIL stop_ign_start busy %b count %0d exp busy 1 count 3", bus.o_busy, bus.o_count); end
    bus.i_stop = 1'b1;
    send(16'h3333, 16'h0333);
    bus.i_stop = 1'b0;
    checks++; if (bus.o_done !== 1'b1 || bus.o_count !== 4'd4)
      begin errors++; $display("FAIL stop_count done %b count %0d exp done 1 count 4", bus.o_done, bus.o_count); end
    rd(3'd3, r, e, v);
    checks++; if (r !== 16'h3333 || e !== 16'h0333)
      begin errors++; $display("FAIL stop_rd3 got %h/%h exp 3333/0333", r, e); end
  endtask

  task automatic test_reset_mid_capture();
    logic [DW-1:0] r, e, xr, xe;
    logic v;
    start(8'd0);
    for (int k = 0; k < 5; k++) send(16'h0400 + 16'(k), 16'h0040 + 16'(k));
    checks++; if (bus.o_count !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", bus.o_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_count !== 4'd0)
      begin errors++; $display("FAIL mid_reset busy %b done %b count %0d exp 0 0 0", bus.o_busy, bus.o_done, bus.o_count); end
    start(8'd0);
    for (int k = 0; k < 2; k++) send(16'h0500 + 16'(k), 16'h0050 + 16'(k));
    stop();
    checks++; if (bus.o_done !== 1'b1 || bus.o_count !== 4'd2)
      begin errors++; $display("FAIL mid_new_count done %b count %0d exp done 1 count 2", bus.o_done, bus.o_count); end
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), r, e, v);
      xr = (a < 2) ? 16'h0500 + 16'(a) : 16'h0400 + 16'(a);
      xe = (a < 2) ? 16'h0050 + 16'(a) : 16'h0040 + 16'(a);
      checks++; if (r !== xr || e !== xe)
        begin errors++; $display("FAIL mid_rd[%0d] got %h/%h exp %h/%h", a, r, e, xr, xe); end
    end
  endtask

  task automatic test_read_first();
    start(8'd0);
    send(16'h1111, 16'h0001);
    send(16'h2222, 16'h0002);
    send(16'hAAAA, 16'h000A);
    stop();
    start(8'd0);
    send(16'h1212, 16'h0011);
    send(16'h2323, 16'h0022);
    bus.i_rd_en     = 1'b1;
    bus.i_rd_addr   = 3'd2;
    bus.i_reference = 16'h5555;
    bus.i_error     = 16'h0005;
    bus.i_valid     = 1'b1;
    tick();
    bus.i_valid     = 1'b0;
    checks++; if (bus.o_rd_reference !== 16'hAAAA || bus.o_rd_error !== 16'h000A || bus.o_rd_valid !== 1'b1)
      begin errors++; $display("FAIL rf_old got %h/%h v%b exp AAAA/000A v1", bus.o_rd_reference, bus.o_rd_error, bus.o_rd_valid); end
    tick();
    checks++; if (bus.o_rd_reference !== 16'h5555 || bus.o_rd_error !== 16'h0005)
      begin errors++; $display("FAIL rf_new got %h/%h exp 5555/0005", bus.o_rd_reference, bus.o_rd_error); end
    bus.i_rd_en = 1'b0;
    tick();
    checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_rd_reference !== 16'h5555)
      begin errors++; $display("FAIL rf_hold valid %b ref %h exp valid 0 ref 5555", bus.o_rd_valid, bus.o_rd_reference); end
    checks++; if (bus.o_busy !== 1'b1 || bus.o_count !== 4'd3)
      begin errors++; $display("FAIL rf_count busy %b count %0d exp busy 1 count 3", bus.o_busy, bus.o_count); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_full_run();
    test_start_stop_together();
    test_decimation();
    test_stop_with_write();
    test_reset_mid_capture();
    test_read_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
